// File: rtl/adder_sum_accumulator.sv
// Frames FRAME_LEN 4-bit adder samples into a running total and offers it on a valid/ready port.
// Define SUM_ACC_WRAP_EN to make accumulator overflow wrap modulo 2^ACC_W instead of saturating.
module adder_sum_accumulator #(
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [SUM_W-1:0]   sum_ext;
  logic [CNT_W-1:0]   count_inc;

  // Extra top bit of the sum exposes the carry beyond the accumulator width.
  assign sum_ext   = {1'b0, acc_q} + SUM_W'({in_cout, in_sum});
  assign count_inc = count_q + CNT_W'(1);

  // Next-state: clear beats everything, then per-state accept / hand-off.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            count_d = count_inc;
            if (sum_ext[ACC_W]) begin
              ovf_d = 1'b1;
`ifdef SUM_ACC_WRAP_EN
              acc_d = sum_ext[ACC_W-1:0];
`else
              acc_d = '1;
`endif
            end else begin
              acc_d = sum_ext[ACC_W-1:0];
            end
            if (count_inc == FRAME_CNT) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and result outputs come straight from flops; no input-to-output paths.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_total = acc_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: directed scenarios plus random traffic against a frame-queue model.
module tb_adder_sum_accumulator;

  localparam int unsigned ACC_W     = 5;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned ACC_MAX   = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sum;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Model: the samples accepted in the current frame.
  int unsigned frame_q[$];

  adder_sum_accumulator #(
    .ACC_W    (ACC_W),
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_cout  (in_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_total(out_total),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  function automatic int unsigned raw_sum();
    int unsigned s = 0;
    foreach (frame_q[i]) s += frame_q[i];
    return s;
  endfunction

  function automatic bit exp_ovf();
    return raw_sum() > ACC_MAX;
  endfunction

  // Sample values are non-negative, so a saturated total stays pinned at max.
  function automatic int unsigned exp_total();
    int unsigned s = raw_sum();
`ifdef SUM_ACC_WRAP_EN
    return s % (ACC_MAX + 1);
`else
    return (s > ACC_MAX) ? ACC_MAX : s;
`endif
  endfunction

  function automatic bit holding();
    return frame_q.size() == FRAME_LEN;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(holding()));
    check({tag, ".in_ready"},  32'(in_ready),  32'(!holding()));
    check({tag, ".out_total"}, 32'(out_total), exp_total());
    check({tag, ".out_count"}, 32'(out_count), frame_q.size());
    check({tag, ".out_ovf"},   32'(out_ovf),   32'(exp_ovf()));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check after it settles.
  task automatic step(input string tag, input logic v, input int unsigned s,
                      input logic rdy, input logic clr);
    bit was_holding;
    in_valid  = v;
    in_sum    = 3'(s);
    in_cout   = s[3];
    out_ready = rdy;
    clear     = clr;
    was_holding = holding();
    @(posedge clk);
    if (clr) frame_q.delete();
    else if (!was_holding && v) frame_q.push_back(s & 32'hF);
    else if (was_holding && rdy) frame_q.delete();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; out_ready = 1'b0;

    // Reset with no clock edge involved.
    #2 rst_n = 1'b0;
    #1 check_all("reset_async");
    #1 rst_n = 1'b1;
    check_all("reset_release");

    // Four samples of 3 with consumer stalled.
    for (int i = 0; i < 4; i++) step("frame_3s", 1'b1, 3, 1'b0, 1'b0);
    check("frame_3s.total_const", 32'(out_total), 32'd12);

    // Backpressure: offered samples are ignored while holding.
    for (int i = 0; i < 5; i++) step("hold_stall", 1'b1, 9, 1'b0, 1'b0);
    step("hold_take", 1'b0, 0, 1'b1, 1'b0);
    check("hold_take.ready_const", 32'(in_ready), 32'd1);

    // Overflow: 15+15+15+1 exceeds 31.
    step("ovf_a", 1'b1, 15, 1'b0, 1'b0);
    step("ovf_b", 1'b1, 15, 1'b0, 1'b0);
    step("ovf_c", 1'b1, 15, 1'b0, 1'b0);
    step("ovf_d", 1'b1, 1, 1'b0, 1'b0);
`ifdef SUM_ACC_WRAP_EN
    check("ovf.total_const", 32'(out_total), 32'd14);
`else
    check("ovf.total_const", 32'(out_total), 32'd31);
`endif
    step("ovf_take", 1'b0, 0, 1'b1, 1'b0);

    // Clear mid-frame drops the concurrent sample.
    step("clr_a", 1'b1, 5, 1'b0, 1'b0);
    step("clr_b", 1'b1, 5, 1'b0, 1'b0);
    step("clr_hit", 1'b1, 5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("after_clr", 1'b1, 1, 1'b0, 1'b0);
    check("after_clr.total_const", 32'(out_total), 32'd4);

    // Clear and out_ready together in HOLD.
    step("clr_in_hold", 1'b1, 2, 1'b1, 1'b1);

    // Async reset while holding a result.
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 7, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    frame_q.delete();
    #1 check_all("rst_in_hold");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("post_rst", 1'b1, 2, 1'b0, 1'b0);
    check("post_rst.total_const", 32'(out_total), 32'd8);
    step("post_rst_take", 1'b0, 0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(3, 0) != 0),
           $urandom_range(15, 0),
           ($urandom_range(1, 0) == 1),
           ($urandom_range(19, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
